// File: rtl/out_port_allocator_pkg.sv
// Shared constants for the output-port allocator: flit-type encodings, port indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package out_port_allocator_pkg;

   localparam int NPORT = 5;   // N, E, W, S, L
   localparam int FT_W  = 3;   // flit-type field width
   localparam int IDX_W = 3;   // width of a binary port index

   // Port index constants (bit positions in req/empty/grant/rd_en)
   localparam logic [IDX_W-1:0] P_N = 3'd0;
   localparam logic [IDX_W-1:0] P_E = 3'd1;
   localparam logic [IDX_W-1:0] P_W = 3'd2;
   localparam logic [IDX_W-1:0] P_S = 3'd3;
   localparam logic [IDX_W-1:0] P_L = 3'd4;

   // Flit-type encodings
   localparam logic [FT_W-1:0] HEADER = 3'd1;
   localparam logic [FT_W-1:0] BODY   = 3'd2;
   localparam logic [FT_W-1:0] TAIL   = 3'd3;

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} alloc_state_t;

   // Binary index of a one-hot port vector (zero for an all-zero vector).
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NPORT-1:0] oh);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < NPORT; i++) begin
         if (oh[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/out_port_allocator_rr_arbiter5.sv
// Five-way round-robin selector: first set req bit at or after ptr, wrapping 4->0.
// Latency: purely combinational. Ports: req[4:0], ptr[2:0] in; one-hot gnt[4:0] out.
// Backpressure: none; gnt is zero when req is zero.
module rr_arbiter5
   import out_port_allocator_pkg::*;
(
   input  logic [NPORT-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NPORT-1:0] gnt
);

   logic [IDX_W:0] idx;
   logic           found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NPORT; k++) begin
         // ptr is always 0..4, so one subtraction is enough to wrap
         idx = {1'b0, ptr} + (IDX_W + 1)'(k);
         if (idx >= (IDX_W + 1)'(NPORT)) idx = idx - (IDX_W + 1)'(NPORT);
         if (!found && req[idx[IDX_W-1:0]]) begin
            gnt[idx[IDX_W-1:0]] = 1'b1;
            found               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/out_port_allocator.sv
// Output-port allocator: round-robin packet-level grant of one output among 5 inputs,
// holding the grant until TAIL, with credit-based flow control toward downstream.
// Latency: grant registered 1 cycle after req sample; pop/valid combinational in BUSY.
// Backpressure: no pop while credit_cnt == 0 or granted FIFO empty; credit_in returns slots.
// Ports: req/empty/flit_type per input in, credit_in pulse in; grant/xbar_sel/credit_cnt/
//        credit_err registered out; rd_en/valid_out combinational out.
module out_port_allocator
   import out_port_allocator_pkg::*;
#(
   parameter int CREDIT_MAX = 4,
   parameter int CW         = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NPORT-1:0]      req,
   input  logic [NPORT-1:0]      empty,
   input  logic [NPORT*FT_W-1:0] flit_type,
   input  logic                  credit_in,
   output logic [NPORT-1:0]      grant,
   output logic [NPORT-1:0]      rd_en,
   output logic [IDX_W-1:0]      xbar_sel,
   output logic                  valid_out,
   output logic [CW-1:0]         credit_cnt,
   output logic                  credit_err
);

   localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);

   alloc_state_t      state_q;
   logic [NPORT-1:0]  grant_q;
   logic [IDX_W-1:0]  xbar_sel_q;
   logic [IDX_W-1:0]  ptr_q;
   logic [CW-1:0]     credit_q, credit_d;
   logic              err_q, err_d;

   logic [NPORT-1:0]  arb_gnt;
   logic [NPORT-1:0]  pop_mask;
   logic              fwd;
   logic [FT_W-1:0]   head_type;

   rr_arbiter5 u_arb (
      .req (req),
      .ptr (ptr_q),
      .gnt (arb_gnt)
   );

   // A flit crosses only for the owning input, with data present and a free downstream slot.
   assign pop_mask  = grant_q & ~empty;
   assign fwd       = (state_q == S_BUSY) && !rst && (credit_q != '0) && (pop_mask != '0);
   assign rd_en     = fwd ? pop_mask : '0;
   assign valid_out = fwd;

   always_comb begin
      head_type = '0;
      for (int i = 0; i < NPORT; i++) begin
         if (xbar_sel_q == IDX_W'(i)) head_type = flit_type[FT_W*i +: FT_W];
      end
   end

   // Simultaneous forward and returned credit cancel out; a credit beyond
   // CREDIT_MAX is dropped and flagged.
   always_comb begin
      credit_d = credit_q;
      err_d    = err_q;
      case ({fwd, credit_in})
         2'b10: credit_d = credit_q - CW'(1);
         2'b01: begin
            if (credit_q == CMAX) err_d    = 1'b1;
            else                  credit_d = credit_q + CW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         xbar_sel_q <= '0;
         ptr_q      <= '0;
         credit_q   <= CMAX;
         err_q      <= 1'b0;
      end else begin
         credit_q <= credit_d;
         err_q    <= err_d;
         case (state_q)
            S_IDLE: begin
               if ((req != '0) && (credit_q != '0)) begin
                  grant_q    <= arb_gnt;
                  xbar_sel_q <= onehot_to_idx(arb_gnt);
                  state_q    <= S_BUSY;
               end
            end
            S_BUSY: begin
               // req is deliberately ignored here: ownership lasts until TAIL leaves.
               if (fwd && (head_type == TAIL)) begin
                  grant_q <= '0;
                  state_q <= S_IDLE;
                  ptr_q   <= (xbar_sel_q == P_L) ? P_N : xbar_sel_q + IDX_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign grant      = grant_q;
   assign xbar_sel   = xbar_sel_q;
   assign credit_cnt = credit_q;
   assign credit_err = err_q;

endmodule

// File: tb/tb_out_port_allocator.sv
// Directed bench for out_port_allocator with a queue model of the five input FIFOs.
// Latency: n/a.
// Backpressure: FIFO model pops on the DUT's rd_en sampled before each edge.
module tb_out_port_allocator;
   import out_port_allocator_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  req;
   logic [4:0]  empty;
   logic [14:0] flit_type;
   logic        credit_in;
   logic [4:0]  grant;
   logic [4:0]  rd_en;
   logic [2:0]  xbar_sel;
   logic        valid_out;
   logic [2:0]  credit_cnt;
   logic        credit_err;

   int checks = 0;
   int errors = 0;

   logic [2:0] fq [5][$];

   always #5 clk = ~clk;

   out_port_allocator #(.CREDIT_MAX(4), .CW(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .empty      (empty),
      .flit_type  (flit_type),
      .credit_in  (credit_in),
      .grant      (grant),
      .rd_en      (rd_en),
      .xbar_sel   (xbar_sel),
      .valid_out  (valid_out),
      .credit_cnt (credit_cnt),
      .credit_err (credit_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < 5; i++) begin
         empty[i]           = (fq[i].size() == 0);
         flit_type[3*i +: 3] = (fq[i].size() == 0) ? 3'd0 : fq[i][0];
      end
      #1;
   endtask

   // One clock: pop what the DUT asked for, drop the credit pulse, settle.
   task automatic tick();
      logic [4:0] p;
      p = rd_en;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         if (p[i] && fq[i].size() != 0) void'(fq[i].pop_front());
      end
      credit_in = 1'b0;
      refresh();
   endtask

   task automatic flush();
      for (int i = 0; i < 5; i++) fq[i].delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      credit_in = 1'b0;
      flush();
      refresh();
      tick();
      tick();
      rst = 1'b0;
      refresh();
   endtask

   int exp_order [6] = '{0, 1, 2, 3, 4, 0};

   initial begin
      rst = 1'b1; req = '0; credit_in = 1'b0; empty = '1; flit_type = '0;
      flush();
      refresh();
      tick();
      tick();
      // reset state
      chk("rst_grant",  grant, 0);
      chk("rst_xbar",   xbar_sel, 0);
      chk("rst_credit", credit_cnt, 4);
      chk("rst_err",    credit_err, 0);
      chk("rst_valid",  valid_out, 0);
      rst = 1'b0;
      refresh();

      // ---- single 3-flit packet on input 2 ----
      fq[2].push_back(HEADER); fq[2].push_back(BODY); fq[2].push_back(TAIL);
      req = 5'b00100;
      refresh();
      chk("idle_rd_en", rd_en, 0);
      chk("idle_valid", valid_out, 0);
      tick();
      req = '0;
      refresh();
      chk("p1_grant", grant, 5'b00100);
      chk("p1_xbar",  xbar_sel, 2);
      chk("p1_rd_h",  rd_en, 5'b00100);
      chk("p1_vld_h", valid_out, 1);
      tick();
      chk("p1_cred3", credit_cnt, 3);
      chk("p1_vld_b", valid_out, 1);
      tick();
      chk("p1_cred2", credit_cnt, 2);
      chk("p1_vld_t", valid_out, 1);
      tick();
      chk("p1_cred1",  credit_cnt, 1);
      chk("p1_rel",    grant, 0);
      chk("p1_vld_id", valid_out, 0);
      // ptr should now be 3: inputs 0 and 3 request, 3 wins
      req = 5'b01001;
      refresh();
      tick();
      chk("p1_ptr3", grant, 5'b01000);
      chk("p1_xb3",  xbar_sel, 3);

      // ---- all inputs, single-flit packets, credit returned each forward ----
      do_reset();
      for (int i = 0; i < 5; i++) fq[i].push_back(TAIL);
      fq[0].push_back(TAIL);
      req = 5'b11111;
      refresh();
      for (int n = 0; n < 6; n++) begin
         tick();
         chk($sformatf("rr_gnt%0d", n), grant, 32'(1) << exp_order[n]);
         chk($sformatf("rr_vld%0d", n), valid_out, 1);
         credit_in = 1'b1;
         tick();
         chk($sformatf("rr_idle%0d", n), grant, 0);
         chk($sformatf("rr_cred%0d", n), credit_cnt, 4);
      end
      req = '0;
      refresh();
      tick();

      // ---- credit starvation ----
      do_reset();
      fq[1].push_back(HEADER); fq[1].push_back(BODY); fq[1].push_back(BODY);
      fq[1].push_back(BODY);   fq[1].push_back(TAIL);
      req = 5'b00010;
      refresh();
      tick();
      req = '0;
      refresh();
      for (int n = 0; n < 4; n++) tick();
      chk("cz_cred0", credit_cnt, 0);
      chk("cz_rd_en", rd_en, 0);
      chk("cz_grant", grant, 5'b00010);
      tick();
      chk("cz_hold",  valid_out, 0);
      credit_in = 1'b1;
      refresh();
      chk("cz_rd_same", rd_en, 0);
      tick();
      chk("cz_cred1", credit_cnt, 1);
      chk("cz_rd_one", rd_en, 5'b00010);
      tick();
      chk("cz_cred_back", credit_cnt, 0);
      chk("cz_rel",       grant, 0);
      chk("cz_fifo",      fq[1].size(), 0);

      // ---- credit arithmetic and overflow ----
      credit_in = 1'b1; refresh(); tick();
      credit_in = 1'b1; refresh(); tick();
      chk("ca_cred2", credit_cnt, 2);
      fq[4].push_back(HEADER); fq[4].push_back(TAIL);
      req = 5'b10000;
      refresh();
      tick();
      req = '0;
      credit_in = 1'b1;
      refresh();
      chk("ca_vld", valid_out, 1);
      tick();
      chk("ca_both", credit_cnt, 2);
      tick();
      chk("ca_fwd", credit_cnt, 1);
      for (int n = 0; n < 3; n++) begin
         credit_in = 1'b1; refresh(); tick();
      end
      chk("ca_full", credit_cnt, 4);
      chk("ca_noerr", credit_err, 0);
      credit_in = 1'b1; refresh(); tick();
      chk("ca_ovf_cnt", credit_cnt, 4);
      chk("ca_ovf_err", credit_err, 1);
      tick();
      chk("ca_sticky", credit_err, 1);

      // ---- reset mid-packet ----
      do_reset();
      chk("mr_err_clr", credit_err, 0);
      fq[0].push_back(HEADER); fq[0].push_back(BODY); fq[0].push_back(TAIL);
      req = 5'b00001;
      refresh();
      tick();
      tick();
      chk("mr_cred3", credit_cnt, 3);
      rst = 1'b1;
      refresh();
      chk("mr_rd_rst",  rd_en, 0);
      chk("mr_vld_rst", valid_out, 0);
      tick();
      chk("mr_grant", grant, 0);
      chk("mr_cred",  credit_cnt, 4);
      chk("mr_xbar",  xbar_sel, 0);
      chk("mr_rd",    rd_en, 0);
      rst = 1'b0;
      flush();
      req = 5'b00011;
      refresh();
      tick();
      chk("mr_ptr0", grant, 5'b00001);

      // ---- req dropped mid-packet ----
      do_reset();
      fq[1].push_back(HEADER); fq[1].push_back(BODY); fq[1].push_back(TAIL);
      fq[3].push_back(TAIL);
      req = 5'b01010;
      refresh();
      tick();
      chk("rd_g1", grant, 5'b00010);
      req = 5'b01000;
      refresh();
      tick();
      chk("rd_hold_b", grant, 5'b00010);
      tick();
      chk("rd_hold_t", grant, 5'b00010);
      tick();
      chk("rd_rel", grant, 0);
      tick();
      chk("rd_g3",  grant, 5'b01000);
      chk("rd_x3",  xbar_sel, 3);
      tick();
      chk("rd_end", grant, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/out_port_allocator.md
OUT_PORT_ALLOCATOR -- requirements
Module: out_port_allocator

Interface
REQ-001 SHALL have parameter CREDIT_MAX, default 4: downstream input-buffer depth in flits.
REQ-002 SHALL have parameter CW, default 3: credit counter width; CW SHALL hold CREDIT_MAX.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 5: per-input request for this output, from each input's LBDR port bit; bit order N=0, E=1, W=2, S=3, L=4.
REQ-006 SHALL have port empty, input, 5: per-input FIFO empty flag.
REQ-007 SHALL have port flit_type, input, 15: 3-bit flit type of each input FIFO head; input i occupies bits [3i+2:3i].
REQ-008 SHALL have port credit_in, input, 1: one-cycle pulse; downstream freed one slot.
REQ-009 SHALL have port grant, output, 5: registered one-hot owner of the output; zero when idle.
REQ-010 SHALL have port rd_en, output, 5: combinational FIFO pop, at most one bit set.
REQ-011 SHALL have port xbar_sel, output, 3: registered binary index of the granted input, for the crossbar mux.
REQ-012 SHALL have port valid_out, output, 1: combinational; a flit crosses the output this cycle.
REQ-013 SHALL have port credit_cnt, output, CW: registered count of available downstream slots.
REQ-014 SHALL have port credit_err, output, 1: registered sticky flag set by a credit overflow.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and BUSY.
REQ-016 In IDLE, when req is nonzero and credit_cnt > 0, SHALL select one requester round-robin, register grant and xbar_sel, and enter BUSY on the next edge.
REQ-017 Round-robin search SHALL start at index ptr and wrap from 4 to 0; ptr SHALL reset to 0.
REQ-018 ptr SHALL be set to (granted index + 1) mod 5 when the grant is released.
REQ-019 In IDLE, grant SHALL be zero, and rd_en and valid_out SHALL be 0.
REQ-020 In BUSY, rd_en[g] and valid_out SHALL be 1 iff grant[g], ~empty[g] and credit_cnt > 0.
REQ-021 A forwarded flit with flit_type == `TAIL SHALL release the grant: grant cleared, state IDLE on the next edge, so there is no back-to-back regrant in that cycle.
REQ-022 A forwarded HEADER or BODY flit in BUSY SHALL keep the grant; deassertion of req[g] during BUSY SHALL be ignored.
REQ-023 Credit update rules:
- forward only: credit_cnt decrements by 1.
- credit_in only: credit_cnt increments by 1.
- both in the same cycle: credit_cnt is unchanged.
REQ-024 credit_in while credit_cnt == CREDIT_MAX with no forward SHALL leave credit_cnt unchanged and set credit_err.
REQ-025 credit_cnt SHALL never underflow; this is guaranteed by REQ-020.
REQ-026 Grant-to-first-flit latency SHALL be 1 cycle after the req sample, provided the FIFO is non-empty and credit is available.

Reset
REQ-027 During rst SHALL drive state to IDLE, grant to 0, xbar_sel to 0, ptr to 0, credit_cnt to CREDIT_MAX and credit_err to 0.
REQ-028 rst asserted mid-packet SHALL abort the grant with no tail required; rd_en and valid_out SHALL be 0 while rst is high.

Structure
REQ-029 Flit-type encodings (`HEADER, `BODY, `TAIL), the 3-bit flit-type width and the port index constants SHALL come from the shared include parameters.v.
REQ-030 The round-robin selector SHALL be a sub-module named rr_arbiter5: inputs req and ptr, output one-hot gnt, purely combinational.

Verification
REQ-031 Reset, then req=5'b00100 with FIFO 2 holding H,B,T -> grant=5'b00100 next cycle, xbar_sel=2, valid_out for 3 consecutive cycles, credit_cnt 4->1, IDLE, ptr=3.
REQ-032 req=5'b11111 held, each input sending single-flit H=T packets, credit_in pulsed every forward -> grants in order 0,1,2,3,4,0, one idle cycle between each.
REQ-033 credit_cnt=0 in BUSY with FIFO non-empty -> rd_en=0; one credit_in pulse -> exactly one flit forwarded, credit_cnt returns to 0.
REQ-034 credit_in coinciding with a forward at credit_cnt=2 -> credit_cnt stays 2; credit_in at credit_cnt=4 with no forward -> stays 4 and credit_err=1.
REQ-035 rst asserted after a HEADER of a 3-flit packet is forwarded -> next cycle grant=0, credit_cnt=4, ptr=0, no rd_en.
REQ-036 req[1] dropped mid-packet while req[3]=1 -> grant stays 5'b00010 until TAIL forwarded, then input 3 granted.
